rs_cdb_snoop: RTL and testbench
===============================

Name: rs_cdb_snoop

Overview:
- Reservation station that is the receive side of the common data bus.
- Holds up to DEPTH dispatched instructions whose operands may still be pending on ROB tags.
- Snoops all 8 CDB slots every cycle and captures values whose tag matches a pending operand.
- Issues the oldest fully-ready entry to its functional unit over a valid/ready handshake.

Parameters:
DEPTH, 4, number of station entries (power of two, 2..8)
TAG_W, 3, ROB tag width; must equal width of the cdb_data tag field
DATA_W, 32, operand/result width; must equal width of the cdb_data data field
OP_W, 4, functional-unit opcode width carried through unchanged

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
cdb  in  tomasula_types::cdb_data [8]  broadcast slots; fields used: tag (TAG_W), data (DATA_W)
cdb_valid  in  8  per-slot broadcast-valid; slot i considered only when cdb_valid[i]=1
flush  in  1  synchronous squash of all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  station can accept dispatch this cycle
disp_op  in  OP_W  opcode
disp_dest  in  TAG_W  destination ROB tag
disp_j_rdy, disp_k_rdy  in  1 each  operand already holds a value
disp_j_val, disp_k_val  in  DATA_W each  operand value (valid when *_rdy=1)
disp_j_tag, disp_k_tag  in  TAG_W each  producer tag (used when *_rdy=0)
iss_valid  out  1  an entry is presented for issue
iss_ready  in  1  functional unit accepts
iss_op  out  OP_W  opcode of presented entry
iss_dest  out  TAG_W  destination tag of presented entry
iss_a, iss_b  out  DATA_W each  operand j / k values
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=1 at edge): all entries invalid, age state cleared. count=0, iss_valid=0, disp_ready=1. iss_op/iss_dest/iss_a/iss_b=0.
- Entry state: busy, op, dest, j_rdy, j_val, j_tag, k_rdy, k_val, k_tag, age.
- disp_ready = (count < DEPTH), from registered state only. A same-cycle issue does not free a slot for that cycle's dispatch.
- Dispatch fires when disp_valid && disp_ready && !flush.
- Fired dispatch writes the lowest-index free entry and marks it youngest.
- Dispatch-cycle snoop: if an operand has *_rdy=0 and any valid CDB slot carries the same tag that cycle, the entry is written with rdy=1 and that slot's data.
- Snoop, busy entries: for each pending operand, if cdb_valid[i] && cdb[i].tag==operand tag, set rdy=1 and capture cdb[i].data at the edge.
- Multiple matching slots: the lowest slot index wins.
- Both operands of one entry may be captured in the same cycle.
- Issue candidate = busy && j_rdy && k_rdy, using registered state.
- iss_valid=1 when any candidate exists. Outputs are combinational from the oldest candidate (earliest dispatched).
- Age ordering uses an age matrix or equivalent; ties are impossible.
- Latency: an operand captured at edge N makes the entry issuable in cycle N+1. No CDB-to-issue bypass. A dispatch with both operands ready is issuable the cycle after dispatch.
- Issue fires when iss_valid && iss_ready: the entry is cleared at the edge and removed from the age order.
- If iss_ready=0, the same entry stays presented. An older entry becoming ready preempts it in the next cycle.
- count update: +1 on fired dispatch, −1 on fired issue; both in one cycle leaves count unchanged.
- flush=1: all entries cleared at the edge and count=0. Blocks that cycle's dispatch. An issue handshake in that cycle is still reported on outputs but has no state effect beyond the clear.
- rst has priority over flush.
- Reset or flush mid-operation drops pending entries with no side effects.
- Tags in cdb_valid=0 slots are never matched, even if equal.

Test Plan:
- Reset then idle → count=0, disp_ready=1, iss_valid=0 for 10 cycles, ignoring cdb traffic with cdb_valid=0.
- Dispatch op=3, dest=2, j ready val 0x10, k pending tag 5. Next cycle cdb_valid=8'h04, cdb[2]={tag 5, data 0x20} → iss_valid=1 the following cycle with iss_a=0x10, iss_b=0x20, iss_dest=2.
- Same-cycle capture: dispatch k pending tag 6 while cdb[7]={tag 6, data 0xAB} valid → entry issuable next cycle with iss_b=0xAB.
- Fill 4 entries, all pending, iss_ready=1 → disp_ready=0, count=4. Broadcast the tags for entries 2 and 0 together → entry dispatched first issues first, then the other, count 4→3→2.
- Two valid slots with the same tag 1 (slot 3 data 0x11, slot 6 data 0x66) → captured value 0x11.
- iss_ready=0 for 5 cycles with 2 ready entries → iss outputs stable on the oldest. Then flush=1 with disp_valid=1 → count=0, iss_valid=0 next cycle, dispatch not accepted.

Source files
------------

// File: rtl/tomasula_types.sv
// tomasula_types: shared CDB broadcast slot type (tag + data)
package tomasula_types;
    typedef struct packed {
        logic [2:0]  tag;
        logic [31:0] data;
    } cdb_data;
endpackage

// File: rtl/rs_cdb_snoop_if.sv
// rs_cdb_snoop_if: CDB, dispatch and issue bundle for the reservation station
// master: CDB/dispatch producer and functional unit; slave: the station itself
interface rs_cdb_snoop_if #(
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 3
);
    tomasula_types::cdb_data cdb [8];
    logic [7:0]        cdb_valid;
    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_dest;
    logic              disp_j_rdy;
    logic              disp_k_rdy;
    logic [DATA_W-1:0] disp_j_val;
    logic [DATA_W-1:0] disp_k_val;
    logic [TAG_W-1:0]  disp_j_tag;
    logic [TAG_W-1:0]  disp_k_tag;
    logic              iss_valid;
    logic              iss_ready;
    logic [OP_W-1:0]   iss_op;
    logic [TAG_W-1:0]  iss_dest;
    logic [DATA_W-1:0] iss_a;
    logic [DATA_W-1:0] iss_b;
    logic [CNT_W-1:0]  count;
    modport master (
        output cdb, cdb_valid, flush, disp_valid, disp_op, disp_dest, disp_j_rdy, disp_k_rdy,
               disp_j_val, disp_k_val, disp_j_tag, disp_k_tag, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_dest, iss_a, iss_b, count
    );
    modport slave (
        input  cdb, cdb_valid, flush, disp_valid, disp_op, disp_dest, disp_j_rdy, disp_k_rdy,
               disp_j_val, disp_k_val, disp_j_tag, disp_k_tag, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_dest, iss_a, iss_b, count
    );
endinterface

// File: rtl/rs_cdb_snoop.sv
// rs_cdb_snoop: reservation station snooping 8 CDB slots, issuing oldest ready entry
// ports: clk, rst (sync active-high), bus (slave: cdb/cdb_valid/flush in, dispatch in, issue out, count out)
module rs_cdb_snoop #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input logic clk,
    input logic rst,
    rs_cdb_snoop_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);
    logic [DEPTH-1:0]  busy, jr, kr, cand, jh, kh;
    logic [OP_W-1:0]   op   [DEPTH];
    logic [TAG_W-1:0]  dest [DEPTH];
    logic [TAG_W-1:0]  jt   [DEPTH];
    logic [TAG_W-1:0]  kt   [DEPTH];
    logic [DATA_W-1:0] jv   [DEPTH];
    logic [DATA_W-1:0] kv   [DEPTH];
    logic [DATA_W-1:0] jd   [DEPTH];
    logic [DATA_W-1:0] kd   [DEPTH];
    // ob[e][a]: entry a was dispatched before entry e
    logic [DEPTH-1:0]  ob   [DEPTH];
    logic [CW-1:0]     cnt;
    logic              djh, dkh, disp_fire, iss_fire;
    logic [DATA_W-1:0] djd, dkd;
    logic [IW-1:0]     sel, fr;
    // Slots scanned high to low so the lowest matching slot is the last writer
    always_comb begin
        djh = 1'b0;
        dkh = 1'b0;
        djd = '0;
        dkd = '0;
        jh = '0;
        kh = '0;
        for (int e = 0; e < DEPTH; e++) begin
            jd[e] = '0;
            kd[e] = '0;
        end
        for (int s = 7; s >= 0; s--) begin
            if (bus.cdb_valid[s]) begin
                if (bus.cdb[s].tag == bus.disp_j_tag) begin
                    djh = 1'b1;
                    djd = bus.cdb[s].data;
                end
                if (bus.cdb[s].tag == bus.disp_k_tag) begin
                    dkh = 1'b1;
                    dkd = bus.cdb[s].data;
                end
                for (int e = 0; e < DEPTH; e++) begin
                    if (bus.cdb[s].tag == jt[e]) begin
                        jh[e] = 1'b1;
                        jd[e] = bus.cdb[s].data;
                    end
                    if (bus.cdb[s].tag == kt[e]) begin
                        kh[e] = 1'b1;
                        kd[e] = bus.cdb[s].data;
                    end
                end
            end
        end
    end
    always_comb begin
        cand = busy & jr & kr;
        sel = '0;
        fr = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (!busy[e]) fr = IW'(e);
            if (cand[e] && !(|(cand & ob[e]))) sel = IW'(e);
        end
        bus.disp_ready = cnt < CW'(DEPTH);
        bus.iss_valid = |cand;
        bus.iss_op = bus.iss_valid ? op[sel] : '0;
        bus.iss_dest = bus.iss_valid ? dest[sel] : '0;
        bus.iss_a = bus.iss_valid ? jv[sel] : '0;
        bus.iss_b = bus.iss_valid ? kv[sel] : '0;
        bus.count = cnt;
        disp_fire = bus.disp_valid && bus.disp_ready && !bus.flush;
        iss_fire = bus.iss_valid && bus.iss_ready;
    end
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            busy <= '0;
            cnt <= '0;
            for (int e = 0; e < DEPTH; e++) ob[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (busy[e] && !jr[e] && jh[e]) begin
                    jr[e] <= 1'b1;
                    jv[e] <= jd[e];
                end
                if (busy[e] && !kr[e] && kh[e]) begin
                    kr[e] <= 1'b1;
                    kv[e] <= kd[e];
                end
            end
            if (iss_fire) busy[sel] <= 1'b0;
            if (disp_fire) begin
                busy[fr] <= 1'b1;
                op[fr] <= bus.disp_op;
                dest[fr] <= bus.disp_dest;
                jr[fr] <= bus.disp_j_rdy || djh;
                kr[fr] <= bus.disp_k_rdy || dkh;
                jv[fr] <= bus.disp_j_rdy ? bus.disp_j_val : djd;
                kv[fr] <= bus.disp_k_rdy ? bus.disp_k_val : dkd;
                jt[fr] <= bus.disp_j_tag;
                kt[fr] <= bus.disp_k_tag;
                // New entry is younger than every occupant; stale bits naming this slot are wiped
                for (int e = 0; e < DEPTH; e++) ob[e][fr] <= 1'b0;
                ob[fr] <= busy;
            end
            cnt <= cnt + CW'(disp_fire) - CW'(iss_fire);
        end
    end
endmodule

// File: tb/tb_rs_cdb_snoop.sv
// tb_rs_cdb_snoop: scoreboard bench for the CDB-snooping reservation station
module tb_rs_cdb_snoop;
    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    rs_cdb_snoop_if #(.TAG_W(3), .DATA_W(32), .OP_W(4), .CNT_W(3)) bus ();
    rs_cdb_snoop #(.DEPTH(4), .TAG_W(3), .DATA_W(32), .OP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && bus.iss_valid && bus.iss_ready) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue dest=%0h a=%0h b=%0h", bus.iss_dest, bus.iss_a, bus.iss_b);
            end else begin
                e = q.pop_front();
                if ({bus.iss_op, bus.iss_dest, bus.iss_a, bus.iss_b} !== e) begin
                    errors++;
                    $display("FAIL issue act=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", bus.iss_op, bus.iss_dest,
                             bus.iss_a, bus.iss_b, e.op, e.dest, e.a, e.b);
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clr_cdb();
        bus.cdb_valid = '0;
        for (int s = 0; s < 8; s++) bus.cdb[s] = '{tag: 3'(s), data: 32'hDEAD0000 + s};
    endtask
    task automatic set_slot(input int s, input logic [2:0] t, input logic [31:0] d);
        bus.cdb[s] = '{tag: t, data: d};
        bus.cdb_valid[s] = 1'b1;
    endtask
    task automatic disp(input logic [3:0] o, input logic [2:0] d, input logic j_r, input logic [31:0] j_v,
                        input logic [2:0] j_t, input logic k_r, input logic [31:0] k_v, input logic [2:0] k_t);
        bus.disp_valid = 1'b1;
        bus.disp_op = o;
        bus.disp_dest = d;
        bus.disp_j_rdy = j_r;
        bus.disp_j_val = j_v;
        bus.disp_j_tag = j_t;
        bus.disp_k_rdy = k_r;
        bus.disp_k_val = k_v;
        bus.disp_k_tag = k_t;
        step();
        bus.disp_valid = 1'b0;
    endtask
    initial begin
        bus.flush = 1'b0;
        bus.disp_valid = 1'b0;
        bus.disp_op = '0;
        bus.disp_dest = '0;
        bus.disp_j_rdy = 1'b0;
        bus.disp_k_rdy = 1'b0;
        bus.disp_j_val = '0;
        bus.disp_k_val = '0;
        bus.disp_j_tag = '0;
        bus.disp_k_tag = '0;
        bus.iss_ready = 1'b1;
        clr_cdb();
        step();
        step();
        rst = 1'b0;
        // Idle: invalid CDB slots carrying tags must be ignored
        for (int c = 0; c < 10; c++) begin
            chk("idle_count", 32'(bus.count), 0);
            chk("idle_disp_ready", 32'(bus.disp_ready), 1);
            chk("idle_iss_valid", 32'(bus.iss_valid), 0);
            chk("idle_iss_outs", {bus.iss_op, bus.iss_dest, bus.iss_a[24:0]} | bus.iss_b, 0);
            step();
        end
        // Operand k captured from slot 2 one cycle after dispatch
        q.push_back('{op: 4'd3, dest: 3'd2, a: 32'h10, b: 32'h20});
        disp(4'd3, 3'd2, 1'b1, 32'h10, 3'd0, 1'b0, 32'h0, 3'd5);
        chk("pend_count", 32'(bus.count), 1);
        set_slot(2, 3'd5, 32'h20);
        chk("pend_not_issuable", 32'(bus.iss_valid), 0);
        step();
        clr_cdb();
        chk("capture_issuable", 32'(bus.iss_valid), 1);
        step();
        chk("after_issue_count", 32'(bus.count), 0);
        // Capture on the dispatch cycle itself
        q.push_back('{op: 4'd5, dest: 3'd3, a: 32'h7, b: 32'hAB});
        set_slot(7, 3'd6, 32'hAB);
        disp(4'd5, 3'd3, 1'b1, 32'h7, 3'd0, 1'b0, 32'h0, 3'd6);
        clr_cdb();
        chk("same_cycle_issuable", 32'(bus.iss_valid), 1);
        chk("same_cycle_b", bus.iss_b, 32'hAB);
        step();
        // Fill all four entries with pending j operands
        disp(4'd1, 3'd0, 1'b0, 32'h0, 3'd1, 1'b1, 32'h100, 3'd0);
        disp(4'd2, 3'd1, 1'b0, 32'h0, 3'd2, 1'b1, 32'h100, 3'd0);
        disp(4'd3, 3'd4, 1'b0, 32'h0, 3'd3, 1'b1, 32'h100, 3'd0);
        disp(4'd4, 3'd5, 1'b0, 32'h0, 3'd4, 1'b1, 32'h100, 3'd0);
        chk("full_count", 32'(bus.count), 4);
        chk("full_disp_ready", 32'(bus.disp_ready), 0);
        q.push_back('{op: 4'd1, dest: 3'd0, a: 32'h11, b: 32'h100});
        q.push_back('{op: 4'd3, dest: 3'd4, a: 32'h33, b: 32'h100});
        set_slot(0, 3'd3, 32'h33);
        set_slot(1, 3'd1, 32'h11);
        disp(4'd9, 3'd7, 1'b1, 32'h1, 3'd0, 1'b1, 32'h2, 3'd0);
        clr_cdb();
        chk("full_no_dispatch", 32'(bus.count), 4);
        chk("oldest_first_dest", 32'(bus.iss_dest), 0);
        step();
        chk("drain_count3", 32'(bus.count), 3);
        chk("second_dest", 32'(bus.iss_dest), 4);
        step();
        chk("drain_count2", 32'(bus.count), 2);
        q.push_back('{op: 4'd2, dest: 3'd1, a: 32'h22, b: 32'h100});
        q.push_back('{op: 4'd4, dest: 3'd5, a: 32'h44, b: 32'h100});
        set_slot(5, 3'd4, 32'h44);
        set_slot(6, 3'd2, 32'h22);
        step();
        clr_cdb();
        step();
        step();
        chk("drained_count", 32'(bus.count), 0);
        // Duplicate tag on two valid slots, equal tag in an invalid slot
        q.push_back('{op: 4'd6, dest: 3'd6, a: 32'h11, b: 32'h9});
        disp(4'd6, 3'd6, 1'b0, 32'h0, 3'd1, 1'b1, 32'h9, 3'd0);
        bus.cdb[0] = '{tag: 3'd1, data: 32'h99};
        set_slot(3, 3'd1, 32'h11);
        set_slot(6, 3'd1, 32'h66);
        step();
        clr_cdb();
        chk("dup_tag_a", bus.iss_a, 32'h11);
        step();
        // Stall: C pending (oldest), A and B ready
        bus.iss_ready = 1'b0;
        disp(4'd10, 3'd3, 1'b0, 32'h0, 3'd2, 1'b1, 32'hC, 3'd0);
        disp(4'd7, 3'd7, 1'b1, 32'h1, 3'd0, 1'b1, 32'h2, 3'd0);
        disp(4'd8, 3'd0, 1'b1, 32'h3, 3'd0, 1'b1, 32'h4, 3'd0);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(bus.iss_valid), 1);
            chk("stall_dest", 32'(bus.iss_dest), 7);
            chk("stall_a", bus.iss_a, 32'h1);
            step();
        end
        chk("stall_count", 32'(bus.count), 3);
        set_slot(4, 3'd2, 32'h5);
        step();
        clr_cdb();
        chk("preempt_dest", 32'(bus.iss_dest), 3);
        chk("preempt_a", bus.iss_a, 32'h5);
        bus.flush = 1'b1;
        disp(4'd11, 3'd2, 1'b1, 32'h1, 3'd0, 1'b1, 32'h1, 3'd0);
        bus.flush = 1'b0;
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_iss_valid", 32'(bus.iss_valid), 0);
        step();
        chk("flush_no_dispatch", 32'(bus.count), 0);
        bus.iss_ready = 1'b1;
        step();
        step();
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end
endmodule
